// File: rtl/gmii_rx_pkg.sv
// rtl/gmii_rx_pkg.sv - shared types and constants for the GMII receive frame controller
package gmii_rx_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         MAX_PREAMBLE  = 7;
  localparam int         LEN_W         = 11;

  function automatic logic is_armed(input rx_state_e s);
    return (s == ST_IDLE) || (s == ST_PREAMBLE) || (s == ST_DATA) || (s == ST_DROP);
  endfunction

endpackage

// File: rtl/gmii_rx_frame_ctrl_cdc_sync2.sv
// rtl/gmii_rx_frame_ctrl_cdc_sync2.sv - two-flop synchroniser, resets to 0
module cdc_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
    end
  end

  assign d_out = sync_q;

endmodule

// File: rtl/gmii_rx_frame_ctrl.sv
// rtl/gmii_rx_frame_ctrl.sv - GMII receive bring-up sequencing, preamble/SFD strip, framing and stats
module gmii_rx_frame_ctrl
  import gmii_rx_pkg::*;
#(
  parameter int LOCK_SETTLE = 1024,
  parameter int MIN_LEN     = 64,
  parameter int MAX_LEN     = 1518,
  parameter int CNT_W       = 16
) (
  input  logic             gmii_rx_clk,
  input  logic             rst,
  input  logic             pll_lock,
  input  logic             rx_en,
  input  logic             gmii_rx_dv,
  input  logic [7:0]       gmii_rxd,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic             rx_err,
  output logic             rx_armed,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int               SETTLE_W    = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_SETTLE - 1);
  localparam logic [LEN_W-1:0] MIN_L       = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MAX_L       = LEN_W'(MAX_LEN);
  localparam logic [2:0]       PRE_LIMIT   = 3'(MAX_PREAMBLE);

  logic lock_s;

  cdc_sync2 u_lock_sync (
    .clk   (gmii_rx_clk),
    .rst   (rst),
    .d_in  (pll_lock),
    .d_out (lock_s)
  );

  rx_state_e           state_q, state_d;
  logic                d1_dv_q, d1_dv_d;
  logic [7:0]          d1_rxd_q, d1_rxd_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [2:0]          pre_cnt_q, pre_cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [7:0]          hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;
  logic                sof_pend_q, sof_pend_d;
  logic                rx_valid_q, rx_valid_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_sof_q, rx_sof_d;
  logic                rx_eof_q, rx_eof_d;
  logic                rx_err_q, rx_err_d;
  logic                rx_armed_q, rx_armed_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                drop_err;
  logic                len_bad;

  assign len_bad = (len_q < MIN_L) || (len_q > MAX_L);

  always_comb begin
    state_d    = state_q;
    d1_dv_d    = gmii_rx_dv;
    d1_rxd_d   = gmii_rxd;
    settle_d   = settle_q;
    pre_cnt_d  = pre_cnt_q;
    len_d      = len_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sof_pend_d = sof_pend_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    rx_sof_d   = 1'b0;
    rx_eof_d   = 1'b0;
    rx_err_d   = 1'b0;
    drop_err   = 1'b0;

    // Lock loss overrides everything; a held byte is flushed as a bad end of frame.
    if (!lock_s && state_q != ST_WAIT_LOCK) begin
      state_d    = ST_WAIT_LOCK;
      hold_vld_d = 1'b0;
      if (state_q == ST_DATA && hold_vld_q) begin
        rx_valid_d = 1'b1;
        rx_data_d  = hold_q;
        rx_sof_d   = sof_pend_q;
        rx_eof_d   = 1'b1;
        rx_err_d   = 1'b1;
      end
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
          end
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) state_d = ST_WAIT_IDLE;
          else                         settle_d = settle_q + SETTLE_W'(1);
        end
        ST_WAIT_IDLE: begin
          if (!d1_dv_q) state_d = ST_IDLE;
        end
        ST_IDLE: begin
          if (d1_dv_q) begin
            if (!rx_en) begin
              state_d = ST_DROP;
            end else if (d1_rxd_q == PREAMBLE_BYTE) begin
              state_d   = ST_PREAMBLE;
              pre_cnt_d = 3'd1;
            end else begin
              state_d  = ST_DROP;
              drop_err = 1'b1;
            end
          end
        end
        ST_PREAMBLE: begin
          if (!d1_dv_q) begin
            state_d  = ST_IDLE;
            drop_err = 1'b1;
          end else if (d1_rxd_q == PREAMBLE_BYTE && pre_cnt_q < PRE_LIMIT) begin
            pre_cnt_d = pre_cnt_q + 3'd1;
          end else if (d1_rxd_q == SFD_BYTE) begin
            state_d    = ST_DATA;
            len_d      = '0;
            hold_vld_d = 1'b0;
            sof_pend_d = 1'b1;
          end else begin
            state_d  = ST_DROP;
            drop_err = 1'b1;
          end
        end
        ST_DATA: begin
          // One-byte hold lets the final byte be tagged with eof when dv drops.
          if (d1_dv_q) begin
            hold_d     = d1_rxd_q;
            hold_vld_d = 1'b1;
            if (len_q != '1) len_d = len_q + LEN_W'(1);
            if (hold_vld_q) begin
              rx_valid_d = 1'b1;
              rx_data_d  = hold_q;
              rx_sof_d   = sof_pend_q;
              sof_pend_d = 1'b0;
            end
          end else begin
            state_d    = ST_IDLE;
            hold_vld_d = 1'b0;
            if (hold_vld_q) begin
              rx_valid_d = 1'b1;
              rx_data_d  = hold_q;
              rx_sof_d   = sof_pend_q;
              rx_eof_d   = 1'b1;
              rx_err_d   = len_bad;
            end else begin
              drop_err = 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (!d1_dv_q) state_d = ST_IDLE;
        end
        default: state_d = ST_WAIT_LOCK;
      endcase
    end

    rx_armed_d  = is_armed(state_q);
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (rx_eof_d && !rx_err_d && frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + CNT_W'(1);
    if ((drop_err || (rx_eof_d && rx_err_d)) && err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_WAIT_LOCK;
      d1_dv_q     <= 1'b0;
      d1_rxd_q    <= 8'h00;
      settle_q    <= '0;
      pre_cnt_q   <= 3'd0;
      len_q       <= '0;
      hold_q      <= 8'h00;
      hold_vld_q  <= 1'b0;
      sof_pend_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_sof_q    <= 1'b0;
      rx_eof_q    <= 1'b0;
      rx_err_q    <= 1'b0;
      rx_armed_q  <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      d1_dv_q     <= d1_dv_d;
      d1_rxd_q    <= d1_rxd_d;
      settle_q    <= settle_d;
      pre_cnt_q   <= pre_cnt_d;
      len_q       <= len_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      sof_pend_q  <= sof_pend_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      rx_sof_q    <= rx_sof_d;
      rx_eof_q    <= rx_eof_d;
      rx_err_q    <= rx_err_d;
      rx_armed_q  <= rx_armed_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign rx_sof    = rx_sof_q;
  assign rx_eof    = rx_eof_q;
  assign rx_err    = rx_err_q;
  assign rx_armed  = rx_armed_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
